ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly downstream of ID.
- Registers the ID→EX bus and selects ALU operands. Computes the ALU result and the load/store address, and drives the data SRAM request.
- Publishes its writeback target/data for ID-stage forwarding and forwards everything to MEM on the EX→MEM bus.
- Contains an iterative 32-cycle divider for DIV/DIVU. The divider stalls the front of the pipe via stallreq_for_ex.

---
 rtl/ex_stage_pkg.sv | 46 ++++
 rtl/div_iter.sv | 79 +++++++
 rtl/ex_stage.sv | 163 ++++++++++++++++
 tb/tb_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op bit indices, func codes and divider states
// for the execute stage (optional multiplier: EX_MUL_EN).
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int StallBus     = 6;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle,
// with sign fixup for DIV; DIVU uses raw operands.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] tmp;
  logic [32:0] diff;
  logic        ge;

  assign a_abs = (sgn && opa[31]) ? -opa : opa;
  assign b_abs = (sgn && opb[31]) ? -opb : opb;

  // partial remainder shifted left with next dividend bit
  assign tmp  = {rem, quo[31]};
  assign diff = tmp - {1'b0, dvs};
  assign ge   = tmp >= {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo   <= a_abs;
            rem   <= '0;
            dvs   <= b_abs;
            neg_q <= sgn & (opa[31] ^ opb[31]);
            neg_r <= sgn & opa[31];
            cnt   <= '0;
            state <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          quo <= {quo[30:0], ge};
          rem <= ge ? diff[31:0] : tmp[31:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_IDLE && start) ||
                (state == DIV_RUN);
  assign done = state == DIV_DONE;
  assign q    = neg_q ? -quo : quo;
  assign r    = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand mux, ALU, SRAM request,
// iterative divider; EX_MUL_EN adds a single-cycle MULT/MULTU.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t ex_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_r <= '0;
    end else if (!stall[2]) begin
      ex_r <= id_to_ex_bus;
    end
  end

  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_res;
  logic [5:0]  func;
  logic        is_special;

  assign imm_s = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
  assign imm_z = {16'h0, ex_r.inst[15:0]};
  assign func  = ex_r.inst[5:0];
  assign is_special = ex_r.inst[31:26] == 6'd0;

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      ex_r.sel_src1[0]: src1 = ex_r.rdata1;
      ex_r.sel_src1[1]: src1 = ex_r.pc;
      ex_r.sel_src1[2]: src1 = {27'h0, ex_r.inst[10:6]};
      default:          src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      ex_r.sel_src2[0]: src2 = ex_r.rdata2;
      ex_r.sel_src2[1]: src2 = imm_s;
      ex_r.sel_src2[2]: src2 = 32'd8;
      ex_r.sel_src2[3]: src2 = imm_z;
      default:          src2 = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      ex_r.alu_op[ALU_ADD]:  alu_res = src1 + src2;
      ex_r.alu_op[ALU_SUB]:  alu_res = src1 - src2;
      ex_r.alu_op[ALU_SLT]:
        alu_res = {31'h0, $signed(src1) < $signed(src2)};
      ex_r.alu_op[ALU_SLTU]: alu_res = {31'h0, src1 < src2};
      ex_r.alu_op[ALU_AND]:  alu_res = src1 & src2;
      ex_r.alu_op[ALU_NOR]:  alu_res = ~(src1 | src2);
      ex_r.alu_op[ALU_OR]:   alu_res = src1 | src2;
      ex_r.alu_op[ALU_XOR]:  alu_res = src1 ^ src2;
      ex_r.alu_op[ALU_SLL]:  alu_res = src2 << src1[4:0];
      ex_r.alu_op[ALU_SRL]:  alu_res = src2 >> src1[4:0];
      ex_r.alu_op[ALU_SRA]:
        alu_res = $signed(src2) >>> src1[4:0];
      ex_r.alu_op[ALU_LUI]:  alu_res = {src2[15:0], 16'h0};
      default:               alu_res = '0;
    endcase
  end

  // address always uses base + offset, whatever the ALU op
  assign data_sram_en    = ex_r.ram_en;
  assign data_sram_wen   = ex_r.ram_wen & {4{ex_r.ram_en}};
  assign data_sram_addr  = ex_r.rdata1 + imm_s;
  assign data_sram_wdata = ex_r.rdata2;

  logic        is_div;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign is_div = is_special &&
                  (func == FUNC_DIV || func == FUNC_DIVU);

  div_iter u_div (
    .clk   (clk),
    .rst   (rst),
    .start (is_div),
    .sgn   (func == FUNC_DIV),
    .opa   (ex_r.rdata1),
    .opb   (ex_r.rdata2),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  assign stallreq_for_ex = div_busy;

  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef EX_MUL_EN
  logic        is_mul;
  logic        mul_sgn;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;

  assign is_mul  = is_special &&
                   (func == FUNC_MULT || func == FUNC_MULTU);
  assign mul_sgn = func == FUNC_MULT;
  assign ma = mul_sgn ? {{32{ex_r.rdata1[31]}}, ex_r.rdata1}
                      : {32'h0, ex_r.rdata1};
  assign mb = mul_sgn ? {{32{ex_r.rdata2[31]}}, ex_r.rdata2}
                      : {32'h0, ex_r.rdata2};
  assign prod = ma * mb;

  always_comb begin
    hilo_we = div_done | is_mul;
    {hi, lo} = '0;
    if (div_done)    {hi, lo} = {div_r, div_q};
    else if (is_mul) {hi, lo} = prod;
  end
`else
  assign hilo_we = div_done;
  assign hi = div_done ? div_r : '0;
  assign lo = div_done ? div_q : '0;
`endif

  assign ex_wreg  = ex_r.rf_we;
  assign ex_waddr = ex_r.rf_waddr;
  assign ex_wdata = alu_res;

  assign ex_to_mem_bus = {
    ex_r.pc, ex_r.ram_en, ex_r.ram_wen, ex_r.sel_rf_res,
    ex_r.rf_we, ex_r.rf_waddr, alu_res, hilo_we, hi, lo
  };

  logic unused_bits;
  assign unused_bits = ^{stall[StallBus-1:4], stall[1:0],
                         ex_r.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed table-driven bench for ex_stage plus divider,
// bubble/hold and reset-during-division sequences.
module tb_ex_stage;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;
  localparam logic [11:0] OP_NONE = 12'h000;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_tb;
  logic [158:0] bus;
  logic [140:0] ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         stallreq_for_ex;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // stands in for the pipeline controller: EX stall freezes PC..EX
  assign stall = stallreq_for_ex ? 6'b001111 : stall_tb;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_wreg         (ex_wreg),
    .ex_waddr        (ex_waddr),
    .ex_wdata        (ex_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        en;
    logic [3:0]  wen;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] res;
    logic [31:0] addr;
    logic [3:0]  xwen;
  } vec_t;

  vec_t vt [17];

  function automatic logic [158:0] mk(
    input logic [31:0] pc, inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2,
    input logic en, input logic [3:0] wen, input logic we,
    input logic [4:0] wa, input logic [31:0] r1, r2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, 1'b0, r1, r2};
  endfunction

  function automatic logic [158:0] mkv(input vec_t v);
    return mk(v.pc, v.inst, v.op, v.s1, v.s2, v.en, v.wen,
              v.we, v.wa, v.r1, v.r2);
  endfunction

  task automatic chk(input string nm,
                     input logic [159:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_div(input string nm,
                         input logic [31:0] inst, a, b,
                         input logic [31:0] lo_e, hi_e);
    int n;
    bus = mk(32'hBFC00100, inst, OP_NONE, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b0, 5'd0, a, b);
    @(posedge clk); #1;
    bus = '0;
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, n, 33);
    chk({nm, "_hilo_we"}, ex_to_mem_bus[64], 1'b1);
    chk({nm, "_lo"}, ex_to_mem_bus[31:0], lo_e);
    chk({nm, "_hi"}, ex_to_mem_bus[63:32], hi_e);
    @(posedge clk); #1;
    chk({nm, "_after_done"},
        {stallreq_for_ex, ex_to_mem_bus[64]}, 2'b00);
  endtask

  initial begin
    vt[0]  = '{32'hBFC00000, 32'h2443FFFF, OP_ADD, 3'b001, 4'b0010,
               1'b0, 4'h0, 1'b1, 5'd3, 32'h5, 32'h0,
               32'h00000004, 32'h00000004, 4'h0};
    vt[1]  = '{32'hBFC00004, 32'h3C041234, OP_LUI, 3'b000, 4'b0010,
               1'b0, 4'h0, 1'b1, 5'd4, 32'h0, 32'h0,
               32'h12340000, 32'h00001234, 4'h0};
    vt[2]  = '{32'hBFC00008, 32'h342500FF, OP_OR, 3'b001, 4'b1000,
               1'b0, 4'h0, 1'b1, 5'd5, 32'hF0F00000, 32'h0,
               32'hF0F000FF, 32'hF0F000FF, 4'h0};
    vt[3]  = '{32'hBFC0000C, 32'hAC22FFFC, OP_ADD, 3'b001, 4'b0010,
               1'b1, 4'hF, 1'b0, 5'd2, 32'h1000, 32'hDEAD,
               32'h00000FFC, 32'h00000FFC, 4'hF};
    vt[4]  = '{32'hBFC00010, 32'h00220823, OP_SUB, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h3, 32'h5,
               32'hFFFFFFFE, 32'h00000826, 4'h0};
    vt[5]  = '{32'hBFC00014, 32'h0022082A, OP_SLT, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFFFFFF, 32'h1,
               32'h00000001, 32'h00000829, 4'h0};
    vt[6]  = '{32'hBFC00018, 32'h0022082B, OP_SLTU, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFFFFFF, 32'h1,
               32'h00000000, 32'h0000082A, 4'h0};
    vt[7]  = '{32'hBFC0001C, 32'h00020903, OP_SRA, 3'b100, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0, 32'h80000000,
               32'hF8000000, 32'h00000903, 4'h0};
    vt[8]  = '{32'hBFC00020, 32'h00020902, OP_SRL, 3'b100, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0, 32'h80000000,
               32'h08000000, 32'h00000902, 4'h0};
    vt[9]  = '{32'hBFC00024, 32'h00020900, OP_SLL, 3'b100, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0, 32'h1,
               32'h00000010, 32'h00000900, 4'h0};
    vt[10] = '{32'hBFC00028, 32'h00220827, OP_NOR, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0F0F0F0F, 32'h00FF00FF,
               32'hF000F000, 32'h0F0F1736, 4'h0};
    vt[11] = '{32'hBFC0002C, 32'h00220826, OP_XOR, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0F0F0F0F, 32'h00FF00FF,
               32'h0FF00FF0, 32'h0F0F1735, 4'h0};
    vt[12] = '{32'hBFC00030, 32'h00220824, OP_AND, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'h0F0F0F0F, 32'h00FF00FF,
               32'h000F000F, 32'h0F0F1733, 4'h0};
    vt[13] = '{32'hBFC00010, 32'h0C000000, OP_ADD, 3'b010, 4'b0100,
               1'b0, 4'h0, 1'b1, 5'd31, 32'h0, 32'h0,
               32'hBFC00018, 32'h00000000, 4'h0};
    vt[14] = '{32'h00000000, 32'h00000000, OP_NONE, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b0, 5'd0, 32'h55, 32'h66,
               32'h00000000, 32'h00000055, 4'h0};
    vt[15] = '{32'hBFC00034, 32'hAC22FFFC, OP_ADD, 3'b001, 4'b0010,
               1'b0, 4'hF, 1'b0, 5'd2, 32'h1000, 32'hDEAD,
               32'h00000FFC, 32'h00000FFC, 4'h0};
    vt[16] = '{32'hBFC00038, 32'h00220821, OP_ADD, 3'b001, 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFFFFFF, 32'h2,
               32'h00000001, 32'h00000820, 4'h0};

    rst = 1'b0;
    stall_tb = '0;
    bus = mkv(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", ex_to_mem_bus, '0);
    chk("rst_sram",
        {data_sram_en, data_sram_wen, data_sram_addr,
         data_sram_wdata}, '0);
    chk("rst_fwd", {ex_wreg, ex_waddr, ex_wdata}, '0);
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      bus = mkv(vt[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wdata", i), ex_wdata, vt[i].res);
      chk($sformatf("v%0d_addr", i), data_sram_addr, vt[i].addr);
      chk($sformatf("v%0d_wen", i), data_sram_wen, vt[i].xwen);
      chk($sformatf("v%0d_en", i), data_sram_en, vt[i].en);
      chk($sformatf("v%0d_sdata", i), data_sram_wdata, vt[i].r2);
      chk($sformatf("v%0d_wreg", i), ex_wreg, vt[i].we);
      chk($sformatf("v%0d_waddr", i), ex_waddr, vt[i].wa);
      chk($sformatf("v%0d_bus_pc", i),
          ex_to_mem_bus[140:109], vt[i].pc);
      chk($sformatf("v%0d_bus_res", i),
          ex_to_mem_bus[96:65], vt[i].res);
      chk($sformatf("v%0d_hilo", i),
          {stallreq_for_ex, ex_to_mem_bus[64:0]}, '0);
    end

    // bubble: EX stopped, MEM running
    bus = mkv(vt[0]);
    @(posedge clk); #1;
    bus = mkv(vt[2]);
    stall_tb = 6'b000100;
    @(posedge clk); #1;
    chk("bubble_fwd", {ex_wreg, ex_waddr, ex_wdata}, '0);
    chk("bubble_bus", ex_to_mem_bus, '0);

    // hold: EX and MEM both stopped
    stall_tb = 6'b000000;
    @(posedge clk); #1;
    bus = mkv(vt[1]);
    stall_tb = 6'b001100;
    @(posedge clk); #1;
    chk("hold_wdata", ex_wdata, 32'hF0F000FF);
    chk("hold_waddr", ex_waddr, 5'd5);
    stall_tb = '0;

    run_div("div_m7_2", 32'h0022001A, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_100_m7", 32'h0022001A, 32'd100, 32'hFFFFFFF9,
            32'hFFFFFFF2, 32'h00000002);
    run_div("divu_by0", 32'h0022001B, 32'h10, 32'h0,
            32'hFFFFFFFF, 32'h00000010);
    run_div("divu_big", 32'h0022001B, 32'hFFFFFFFF, 32'h10,
            32'h0FFFFFFF, 32'h0000000F);

    // reset while the divider is at cnt=10
    bus = mk(32'hBFC00200, 32'h0022001A, OP_NONE, 3'b001,
             4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 32'h64, 32'h7);
    @(posedge clk); #1;
    bus = '0;
    repeat (11) @(posedge clk);
    #1;
    chk("mid_run_stallreq", stallreq_for_ex, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_mid_bus", ex_to_mem_bus, '0);
    @(negedge clk);
    rst = 1'b1;
    run_div("div_after_rst", 32'h0022001A, 32'h64, 32'h7,
            32'h0000000E, 32'h00000002);

    // MULT / MULTU: single-cycle when enabled, no-op otherwise
    bus = mk(32'hBFC00300, 32'h00220018, OP_NONE, 3'b001,
             4'b0001, 1'b0, 4'h0, 1'b0, 5'd0,
             32'hFFFFFFFE, 32'h3);
    @(posedge clk); #1;
`ifdef EX_MUL_EN
    chk("mult", {stallreq_for_ex, ex_to_mem_bus[64:0]},
        {2'b01, 64'hFFFFFFFF_FFFFFFFA});
`else
    chk("mult", {stallreq_for_ex, ex_to_mem_bus[64:0]}, '0);
`endif
    bus = mk(32'hBFC00304, 32'h00220019, OP_NONE, 3'b001,
             4'b0001, 1'b0, 4'h0, 1'b0, 5'd0,
             32'hFFFFFFFE, 32'h3);
    @(posedge clk); #1;
`ifdef EX_MUL_EN
    chk("multu", {stallreq_for_ex, ex_to_mem_bus[64:0]},
        {2'b01, 64'h00000002_FFFFFFFA});
`else
    chk("multu", {stallreq_for_ex, ex_to_mem_bus[64:0]}, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
